// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the multi-channel frequency divider.
// Channel index width is fixed at 4 bits, so at most 16 channels are addressable.
package freq_div_pkg;

    localparam int          DEF_WIDTH = 26;
    localparam logic [25:0] DEF_LIM   = 26'd24_999_999;
    localparam int          CH_IDX_W  = 4;

    // True when a configuration index addresses an implemented channel.
    function automatic logic ch_valid(input logic [CH_IDX_W-1:0] idx, input int channels);
        return int'(idx) < channels;
    endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: counter, active/shadow limit pair, square-wave and tick outputs.
// Shadow limits are promoted at a wrap or while disabled; a restart write applies at once.
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_LIM = WIDTH'(DEF_LIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic             restart,
    input  logic [WIDTH-1:0] wr_lim,
    output logic             freq,
    output logic             tick,
    output logic             pend
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_act_q, lim_act_d;
    logic [WIDTH-1:0] lim_shd_q, lim_shd_d;
    logic             pend_q, pend_d;
    logic             freq_q, freq_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d     = cnt_q;
        lim_act_d = lim_act_q;
        lim_shd_d = lim_shd_q;
        pend_d    = pend_q;
        freq_d    = freq_q;
        tick_d    = 1'b0;

        if (wr && restart) begin
            cnt_d     = '0;
            lim_act_d = wr_lim;
            lim_shd_d = wr_lim;
            pend_d    = 1'b0;
            freq_d    = 1'b0;
        end else begin
            if (en) begin
                if (cnt_q < lim_act_q) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else begin
                    cnt_d  = '0;
                    freq_d = ~freq_q;
                    tick_d = 1'b1;
                    if (pend_q) begin
                        lim_act_d = lim_shd_q;
                        pend_d    = 1'b0;
                    end
                end
            end else if (pend_q) begin
                // Disabled: no phase to protect, so promote the shadow right away.
                lim_act_d = lim_shd_q;
                pend_d    = 1'b0;
            end

            // A plain write lands after any promotion above, so it waits for the next wrap.
            if (wr) begin
                lim_shd_d = wr_lim;
                pend_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            lim_act_q <= DEFAULT_LIM;
            lim_shd_q <= DEFAULT_LIM;
            pend_q    <= 1'b0;
            freq_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lim_act_q <= lim_act_d;
            lim_shd_q <= lim_shd_d;
            pend_q    <= pend_d;
            freq_q    <= freq_d;
            tick_q    <= tick_d;
        end
    end

    assign freq = freq_q;
    assign tick = tick_q;
    assign pend = pend_q;

endmodule

// File: rtl/freq_divider_multi.sv
// Multi-channel clock divider / tick generator sharing one limit write port.
// The write port is decoded into per-channel strobes; out-of-range indices are dropped.
module freq_divider_multi
    import freq_div_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               CHANNELS    = 4,
    parameter logic [WIDTH-1:0] DEFAULT_LIM = WIDTH'(DEF_LIM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [WIDTH-1:0]    cfg_lim,
    input  logic                cfg_restart,
    output logic [CHANNELS-1:0] freq,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    logic                cfg_ok;
    logic [CHANNELS-1:0] wr;

    assign cfg_ok = cfg_we && ch_valid(cfg_ch, CHANNELS);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign wr[i] = cfg_ok && (cfg_ch == CH_IDX_W'(i));

        freq_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_LIM (DEFAULT_LIM)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .wr      (wr[i]),
            .restart (cfg_restart),
            .wr_lim  (cfg_lim),
            .freq    (freq[i]),
            .tick    (tick[i]),
            .pend    (pending[i])
        );
    end

endmodule

// File: tb/tb_freq_divider_multi.sv
// Scoreboard bench for freq_divider_multi: a cycle model pushes expected outputs per edge,
// which are popped and compared against the DUT one time unit after that edge.
module tb_freq_divider_multi;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int DEF = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           cfg_we;
    logic [3:0]     cfg_ch;
    logic [W-1:0]   cfg_lim;
    logic           cfg_restart;
    logic [NCH-1:0] freq, tick, pending;

    freq_divider_multi #(
        .WIDTH       (W),
        .CHANNELS    (NCH),
        .DEFAULT_LIM (8'd6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_lim     (cfg_lim),
        .cfg_restart (cfg_restart),
        .freq        (freq),
        .tick        (tick),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] f;
        logic [NCH-1:0] t;
        logic [NCH-1:0] p;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int m_cnt[NCH], m_act[NCH], m_shd[NCH];
    bit m_pend[NCH], m_freq[NCH], m_tick[NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour of one clock edge, driven from the inputs currently applied.
    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit hit;
            hit = cfg_we && (int'(cfg_ch) == c);
            if (rst) begin
                m_cnt[c] = 0; m_act[c] = DEF; m_shd[c] = DEF;
                m_pend[c] = 0; m_freq[c] = 0; m_tick[c] = 0;
            end else if (hit && cfg_restart) begin
                m_cnt[c] = 0; m_act[c] = int'(cfg_lim); m_shd[c] = int'(cfg_lim);
                m_pend[c] = 0; m_freq[c] = 0; m_tick[c] = 0;
            end else begin
                m_tick[c] = 0;
                if (en[c]) begin
                    if (m_cnt[c] < m_act[c]) m_cnt[c]++;
                    else begin
                        m_cnt[c] = 0;
                        m_freq[c] = !m_freq[c];
                        m_tick[c] = 1;
                        if (m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
                    end
                end else if (m_pend[c]) begin
                    m_act[c] = m_shd[c]; m_pend[c] = 0;
                end
                if (hit) begin m_shd[c] = int'(cfg_lim); m_pend[c] = 1; end
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        for (int c = 0; c < NCH; c++) begin
            e.f[c] = m_freq[c]; e.t[c] = m_tick[c]; e.p[c] = m_pend[c];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("freq", 32'(freq), 32'(e.f));
        chk("tick", 32'(tick), 32'(e.t));
        chk("pending", 32'(pending), 32'(e.p));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic cfg_write(input int ch, input int lim, input bit rs);
        cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_lim = W'(lim); cfg_restart = rs;
        cycle();
        cfg_we = 1'b0; cfg_restart = 1'b0;
    endtask

    // Waits for a tick on channel ch, then counts cycles to the following tick.
    task automatic measure_period(input string tag, input int ch, input int expn);
        int n; bit seen;
        n = 0; seen = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (tick[ch]) begin seen = 1; break; end
        end
        if (seen) begin
            for (int k = 0; k < 40; k++) begin
                cycle();
                n++;
                if (tick[ch]) break;
            end
        end
        chk(tag, 32'(n), 32'(expn));
    endtask

    initial begin
        bit found;
        rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_lim = '0; cfg_restart = 1'b0;

        run(2);
        chk("reset_freq", 32'(freq), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);

        // Default limit: tick every DEF+1 enabled cycles.
        rst = 1'b0; en = '1;
        run(16);

        for (int c = 0; c < NCH; c++) cfg_write(c, 3, 1'b1);
        run(3);
        chk("ch3_first_tick_early", 32'(tick[3]), 32'd0);
        cycle();
        chk("ch3_first_tick", 32'(tick[3]), 32'd1);
        measure_period("ch3_period4", 3, 4);
        run(8);

        // Channel 0: lim 9, reprogram to 4 at cnt=2 without restart.
        cfg_write(0, 9, 1'b1);
        run(2);
        cfg_write(0, 4, 1'b0);
        chk("ch0_pending_set", 32'(pending[0]), 32'd1);
        measure_period("ch0_period5", 0, 5);
        chk("ch0_pending_clr", 32'(pending[0]), 32'd0);

        // Channel 1: lim 0 -> tick stuck high, freq at clk/2.
        cfg_write(1, 0, 1'b1);
        run(2);
        chk("ch1_tick_hi", 32'(tick[1]), 32'd1);
        run(4);

        // Channel 2: freeze mid-period, then a write while disabled.
        cfg_write(2, 9, 1'b1);
        run(5);
        en[2] = 1'b0;
        run(7);
        chk("ch2_frozen_tick", 32'(tick[2]), 32'd0);
        en[2] = 1'b1;
        run(12);
        en[2] = 1'b0;
        cfg_write(2, 2, 1'b0);
        cycle();
        chk("ch2_disabled_apply", 32'(pending[2]), 32'd0);
        en[2] = 1'b1;
        run(10);

        // Out-of-range channel index.
        cfg_write(5, 1, 1'b1);
        run(6);

        // Plain write coinciding with a wrap that promotes an older shadow.
        cfg_write(3, 2, 1'b0);
        found = 0;
        for (int k = 0; k < 12; k++) begin
            if (m_cnt[3] == m_act[3]) begin found = 1; break; end
            cycle();
        end
        chk("wrap_align", 32'(found), 32'd1);
        cfg_write(3, 5, 1'b0);
        chk("ch3_tick_on_wrap", 32'(tick[3]), 32'd1);
        chk("ch3_pend_after_wrap", 32'(pending[3]), 32'd1);
        measure_period("ch3_period6", 3, 6);

        // Randomised enables and writes.
        for (int k = 0; k < 300; k++) begin
            en = NCH'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                cfg_write($urandom_range(0, 5), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            end else begin
                cycle();
            end
        end

        // Reset mid-count together with a restart write.
        en = '1; rst = 1'b1;
        cfg_write(0, 1, 1'b1);
        rst = 1'b0;
        chk("rst_freq", 32'(freq), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        run(6);
        chk("rst_default_early", 32'(tick), 32'd0);
        cycle();
        chk("rst_default_tick", 32'(tick), 32'hF);
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
